// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order completion/retire buffer for the dual-issue integer
// pipeline. Allocates up to two entries per cycle, marks them done by tag and
// retires completed head entries onto the register-file update port pair.
// Optional build macro: ROB_DUAL_RETIRE_EN. When it is defined, up to two
// entries retire per cycle. When it is undefined, only slot 0 retires and
// updateEnB and updateAddrB are tied to 0.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_en_A,
  input  logic             alloc_en_B,
  input  logic [4:0]       rd_A,
  input  logic [4:0]       rd_B,
  input  logic             rd_wr_A,
  input  logic             rd_wr_B,
  output logic [TAG_W-1:0] tag_A,
  output logic [TAG_W-1:0] tag_B,
  output logic             alloc_err_A,
  output logic             alloc_err_B,
  input  logic             cmp_en_A,
  input  logic             cmp_en_B,
  input  logic [TAG_W-1:0] cmp_tag_A,
  input  logic [TAG_W-1:0] cmp_tag_B,
  output logic             updateEnA,
  output logic             updateEnB,
  output logic [4:0]       updateAddrA,
  output logic [4:0]       updateAddrB,
  output logic [1:0]       retire_cnt,
  output logic             empty,
  output logic             full
);

  localparam logic [TAG_W:0] DEPTH_P = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]      valid_q, done_q, wr_q;
  logic [DEPTH-1:0][4:0] rd_q;
  logic [TAG_W:0]        head_q, tail_q;
  logic                  upd_en_a_q;
  logic [4:0]            upd_addr_a_q;
  logic [1:0]            ret_cnt_q;

  logic [TAG_W:0]   count, free, need_b;
  logic             grant_a, grant_b;
  logic [TAG_W-1:0] hidx0;
  logic             ret0, ret1;

  // Occupancy is taken from the pointer pair, so the wrap bit separates full from empty.
  assign count = tail_q - head_q;
  assign free  = DEPTH_P - count;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_P);

  // Grants depend on pre-edge occupancy only; retires in the same cycle do not free space.
  assign grant_a     = alloc_en_A && (free != '0);
  assign need_b      = grant_a ? (TAG_W+1)'(2) : (TAG_W+1)'(1);
  assign grant_b     = alloc_en_B && (free >= need_b);
  assign tag_A       = tail_q[TAG_W-1:0];
  assign tag_B       = tail_q[TAG_W-1:0] + TAG_W'(grant_a);
  assign alloc_err_A = alloc_en_A && !grant_a;
  assign alloc_err_B = alloc_en_B && !grant_b;

  // Retire decisions read registered done bits, so completion and retire of an entry
  // always fall on different edges.
  assign hidx0 = head_q[TAG_W-1:0];
  assign ret0  = valid_q[hidx0] && done_q[hidx0];

`ifdef ROB_DUAL_RETIRE_EN
  logic [TAG_W-1:0] hidx1;
  logic             upd_en_b_q;
  logic [4:0]       upd_addr_b_q;

  assign hidx1       = hidx0 + TAG_W'(1);
  assign ret1        = ret0 && valid_q[hidx1] && done_q[hidx1];
  assign updateEnB   = upd_en_b_q;
  assign updateAddrB = upd_addr_b_q;

  // Slot 1 update port register.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_en_b_q   <= 1'b0;
      upd_addr_b_q <= '0;
    end else if (flush) begin
      upd_en_b_q   <= 1'b0;
    end else begin
      upd_en_b_q <= ret1 && wr_q[hidx1];
      if (ret1) upd_addr_b_q <= rd_q[hidx1];
    end
  end
`else
  assign ret1        = 1'b0;
  assign updateEnB   = 1'b0;
  assign updateAddrB = '0;
`endif

  assign updateEnA   = upd_en_a_q;
  assign updateAddrA = upd_addr_a_q;
  assign retire_cnt  = ret_cnt_q;

  // Entry array, pointers and slot 0 update port; reset beats flush, flush beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      done_q       <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      upd_en_a_q   <= 1'b0;
      upd_addr_a_q <= '0;
      ret_cnt_q    <= '0;
    end else if (flush) begin
      valid_q    <= '0;
      done_q     <= '0;
      head_q     <= tail_q;
      upd_en_a_q <= 1'b0;
      ret_cnt_q  <= '0;
    end else begin
      // Completions only touch live entries; new allocations target free ones, so no overlap.
      if (cmp_en_A && valid_q[cmp_tag_A]) done_q[cmp_tag_A] <= 1'b1;
      if (cmp_en_B && valid_q[cmp_tag_B]) done_q[cmp_tag_B] <= 1'b1;
      if (ret0) begin
        valid_q[hidx0] <= 1'b0;
        done_q[hidx0]  <= 1'b0;
      end
`ifdef ROB_DUAL_RETIRE_EN
      if (ret1) begin
        valid_q[hidx1] <= 1'b0;
        done_q[hidx1]  <= 1'b0;
      end
`endif
      if (grant_a) begin
        valid_q[tag_A] <= 1'b1;
        done_q[tag_A]  <= 1'b0;
        rd_q[tag_A]    <= rd_A;
        wr_q[tag_A]    <= rd_wr_A;
      end
      if (grant_b) begin
        valid_q[tag_B] <= 1'b1;
        done_q[tag_B]  <= 1'b0;
        rd_q[tag_B]    <= rd_B;
        wr_q[tag_B]    <= rd_wr_B;
      end
      tail_q     <= tail_q + (TAG_W+1)'(grant_a) + (TAG_W+1)'(grant_b);
      head_q     <= head_q + (TAG_W+1)'(ret0) + (TAG_W+1)'(ret1);
      upd_en_a_q <= ret0 && wr_q[hidx0];
      if (ret0) upd_addr_a_q <= rd_q[hidx0];
      ret_cnt_q  <= {1'b0, ret0} + {1'b0, ret1};
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer. Expectations follow the
// build: with ROB_DUAL_RETIRE_EN defined, two entries retire per cycle.
module tb_reorder_buffer;
  logic       clk = 1'b0;
  logic       rst, flush, alloc_en_A, alloc_en_B, rd_wr_A, rd_wr_B;
  logic [4:0] rd_A, rd_B;
  logic [3:0] tag_A, tag_B, cmp_tag_A, cmp_tag_B;
  logic       alloc_err_A, alloc_err_B, cmp_en_A, cmp_en_B;
  logic       updateEnA, updateEnB, empty, full;
  logic [4:0] updateAddrA, updateAddrB;
  logic [1:0] retire_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  reorder_buffer #(.DEPTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_en_A(alloc_en_A), .alloc_en_B(alloc_en_B),
    .rd_A(rd_A), .rd_B(rd_B), .rd_wr_A(rd_wr_A), .rd_wr_B(rd_wr_B),
    .tag_A(tag_A), .tag_B(tag_B),
    .alloc_err_A(alloc_err_A), .alloc_err_B(alloc_err_B),
    .cmp_en_A(cmp_en_A), .cmp_en_B(cmp_en_B),
    .cmp_tag_A(cmp_tag_A), .cmp_tag_B(cmp_tag_B),
    .updateEnA(updateEnA), .updateEnB(updateEnB),
    .updateAddrA(updateAddrA), .updateAddrB(updateAddrB),
    .retire_cnt(retire_cnt), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; alloc_en_A = 0; alloc_en_B = 0;
    rd_A = 0; rd_B = 0; rd_wr_A = 0; rd_wr_B = 0;
    cmp_en_A = 0; cmp_en_B = 0; cmp_tag_A = 0; cmp_tag_B = 0;
  endtask

  initial begin
    idle();
    // Reset, then idle
    rst = 1; tick(); tick(); rst = 0; tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_enA", updateEnA, 0);
    chk("rst_enB", updateEnB, 0);
    chk("rst_cnt", retire_cnt, 0);

    // Pair allocation at tail 0, out-of-order completion
    alloc_en_A = 1; rd_A = 5; rd_wr_A = 1;
    alloc_en_B = 1; rd_B = 7; rd_wr_B = 1;
    #1;
    chk("pair_tagA", tag_A, 0);
    chk("pair_tagB", tag_B, 1);
    chk("pair_errA", alloc_err_A, 0);
    chk("pair_errB", alloc_err_B, 0);
    tick(); idle();
    cmp_en_A = 1; cmp_tag_A = 1; tick();       // cycle k
    idle(); cmp_en_B = 1; cmp_tag_B = 0; tick(); // cycle k+1
    idle();
    chk("lat_k2_enA", updateEnA, 0);           // cycle k+2
    tick();                                    // cycle k+3
    chk("pair_enA", updateEnA, 1);
    chk("pair_addrA", updateAddrA, 5);
`ifdef ROB_DUAL_RETIRE_EN
    chk("pair_enB", updateEnB, 1);
    chk("pair_addrB", updateAddrB, 7);
    chk("pair_cnt", retire_cnt, 2);
`else
    chk("pair_enB", updateEnB, 0);
    chk("pair_addrB", updateAddrB, 0);
    chk("pair_cnt", retire_cnt, 1);
    tick();
    chk("pair2_enA", updateEnA, 1);
    chk("pair2_addrA", updateAddrA, 7);
    chk("pair2_cnt", retire_cnt, 1);
`endif
    tick();
    chk("pair_done_cnt", retire_cnt, 0);
    chk("pair_done_empty", empty, 1);

    // Fill from a clean reset: 15 entries, then both request with one slot left
    rst = 1; tick(); idle();
    for (int i = 0; i < 15; i++) begin
      alloc_en_A = 1; rd_A = 5'(i); rd_wr_A = 1; tick();
    end
    idle();
    chk("fill15_full", full, 0);
    alloc_en_A = 1; alloc_en_B = 1; rd_A = 15; rd_wr_A = 1; rd_B = 16; rd_wr_B = 1;
    #1;
    chk("last_tagA", tag_A, 15);
    chk("last_errA", alloc_err_A, 0);
    chk("last_errB", alloc_err_B, 1);
    tick(); idle();
    chk("full_set", full, 1);
    chk("full_not_empty", empty, 0);
    alloc_en_A = 1; #1;
    chk("full_errA", alloc_err_A, 1);
    idle();

    // Drain all 16; tag 0 completed by both ports at once
    for (int t = 0; t < 16; t++) begin
      cmp_en_A = 1; cmp_tag_A = 4'(t);
      cmp_en_B = (t == 0); cmp_tag_B = 4'(t);
      tick();
    end
    idle();
    repeat (20) tick();
    chk("drain16_empty", empty, 1);

    // Move head to 14 with 14 non-writing entries
    for (int i = 0; i < 14; i++) begin
      alloc_en_A = 1; rd_A = 0; rd_wr_A = 0; tick();
    end
    idle();
    for (int t = 0; t < 14; t++) begin
      cmp_en_A = 1; cmp_tag_A = 4'(t); tick();
    end
    idle();
    repeat (20) tick();
    chk("drain14_empty", empty, 1);

    // Wrap: four entries across the index boundary
    alloc_en_A = 1; rd_A = 20; rd_wr_A = 1; alloc_en_B = 1; rd_B = 21; rd_wr_B = 1;
    #1;
    chk("wrap_tagA0", tag_A, 14);
    chk("wrap_tagB0", tag_B, 15);
    tick();
    rd_A = 22; rd_B = 23; #1;
    chk("wrap_tagA1", tag_A, 0);
    chk("wrap_tagB1", tag_B, 1);
    tick(); idle();
    cmp_en_A = 1; cmp_tag_A = 1;  tick();
    cmp_tag_A = 0;  tick();
    cmp_tag_A = 15; tick();
    cmp_tag_A = 14; tick();                    // cycle k
    idle();
    chk("wrap_k1_enA", updateEnA, 0);          // cycle k+1
    tick();
`ifdef ROB_DUAL_RETIRE_EN
    chk("wrap_r0_addrA", updateAddrA, 20);
    chk("wrap_r0_addrB", updateAddrB, 21);
    chk("wrap_r0_cnt", retire_cnt, 2);
    tick();
    chk("wrap_r1_addrA", updateAddrA, 22);
    chk("wrap_r1_addrB", updateAddrB, 23);
    chk("wrap_r1_cnt", retire_cnt, 2);
`else
    for (int i = 0; i < 4; i++) begin
      chk("wrap_r_enA", updateEnA, 1);
      chk("wrap_r_addrA", updateAddrA, 20 + i);
      chk("wrap_r_cnt", retire_cnt, 1);
      if (i < 3) tick();
    end
`endif
    tick();
    chk("wrap_end_cnt", retire_cnt, 0);
    chk("wrap_end_empty", empty, 1);

    // Non-writing head entry
    alloc_en_A = 1; rd_A = 9; rd_wr_A = 0; #1;
    chk("nowr_tagA", tag_A, 2);
    tick(); idle();
    cmp_en_A = 1; cmp_tag_A = 2; tick(); idle(); tick();
    chk("nowr_cnt", retire_cnt, 1);
    chk("nowr_enA", updateEnA, 0);
    tick();
    chk("nowr_after_cnt", retire_cnt, 0);
    chk("nowr_empty", empty, 1);

    // Flush with a done head and a concurrent allocation
    alloc_en_A = 1; rd_A = 11; rd_wr_A = 1; #1;
    chk("fl_tagA", tag_A, 3);
    tick(); idle();
    cmp_en_A = 1; cmp_tag_A = 3; tick(); idle();
    flush = 1; alloc_en_A = 1; rd_A = 12; rd_wr_A = 1; #1;
    chk("fl_errA", alloc_err_A, 0);
    tick(); idle();
    chk("fl_empty", empty, 1);
    chk("fl_enA", updateEnA, 0);
    chk("fl_cnt", retire_cnt, 0);
    // Stale completions: flushed tag 3 and not-yet-allocated tag 4
    cmp_en_B = 1; cmp_tag_B = 3; cmp_en_A = 1; cmp_tag_A = 4; tick(); idle();
    alloc_en_A = 1; rd_A = 13; rd_wr_A = 1; #1;
    chk("fl_next_tagA", tag_A, 4);
    tick(); idle();
    repeat (3) tick();
    chk("stale_enA", updateEnA, 0);
    chk("stale_not_empty", empty, 0);

    // Reset overrides a simultaneous allocation
    rst = 1; alloc_en_A = 1; tick(); idle();
    chk("rst2_empty", empty, 1);
    chk("rst2_cnt", retire_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
